// File: rtl/jt12_timer_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_timer_bank_if
//  Description : Control/status bundle of the jt12 timer bank: tick enable,
//                preload values, run levels, flag controls and the overflow,
//                flag and interrupt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt12_timer_bank_if #(
    parameter int NTIMERS = 2,
    parameter int W       = 10
);
    logic                 clk_en;
    logic [NTIMERS*W-1:0] value;
    logic [NTIMERS-1:0]   load;
    logic [NTIMERS-1:0]   enable_irq;
    logic [NTIMERS-1:0]   clr_flag;
    logic [NTIMERS-1:0]   flag;
    logic [NTIMERS-1:0]   overflow;
    logic                 irq_n;

    // Host side: drives controls, observes status
    modport master (
        output clk_en, value, load, enable_irq, clr_flag,
        input  flag, overflow, irq_n
    );

    // Timer bank side
    modport slave (
        input  clk_en, value, load, enable_irq, clr_flag,
        output flag, overflow, irq_n
    );
endinterface
`default_nettype wire

// File: rtl/jt12_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_timer_bank
//  Description : Bank of NTIMERS independent up-counting timers. Each timer
//                has a power-of-two prescaler, reloads from its preload value
//                on overflow, emits a one-cycle overflow pulse and sets a
//                sticky flag. irq_n is the registered NOR of all flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt12_timer_bank #(
    parameter int NTIMERS = 2,
    parameter int W       = 10,
    parameter int PRE0    = 1,
    parameter int PREN    = 16
) (
    input wire              clk,
    input wire              rst,
    jt12_timer_bank_if.slave bus
);

    // Per-timer control qualifiers
    logic [NTIMERS-1:0] r_load_q;     // load level sampled on the last tick
    logic [NTIMERS-1:0] r_armed;      // load seen low since reset
    logic [NTIMERS-1:0] r_flag;
    logic [NTIMERS-1:0] r_overflow;
    logic               r_irq_n;

    logic [NTIMERS-1:0] w_load_rise;  // accepted load edge on this tick
    logic [NTIMERS-1:0] w_run_tick;   // running tick (prescaler advances)
    logic [NTIMERS-1:0] w_count_tick; // prescaler wraps, counter advances
    logic [NTIMERS-1:0] w_wrap;       // counter overflows this tick
    logic [NTIMERS-1:0] w_flag_nxt;

    // A load edge is only honoured once load has been seen low after reset,
    // so a load held high through reset leaves the timer idle until it
    // toggles. Running requires the same arming.
    assign w_load_rise = {NTIMERS{bus.clk_en}} & bus.load & ~r_load_q & r_armed;
    assign w_run_tick  = {NTIMERS{bus.clk_en}} & bus.load &  r_load_q & r_armed;

    genvar i;
    generate
        for (i = 0; i < NTIMERS; i = i + 1) begin : g_timer
            localparam int c_RATIO = (i == 0) ? PRE0 : PREN;
            localparam int c_PBITS = $clog2(c_RATIO);

            logic [W-1:0] r_cnt;
            logic [W-1:0] w_value;

            assign w_value   = bus.value[i*W +: W];
            assign w_wrap[i] = w_count_tick[i] & (&r_cnt);

            if (c_PBITS == 0) begin : g_nopre
                // Ratio 1: every running tick is a count tick
                assign w_count_tick[i] = w_run_tick[i];
            end else begin : g_pre
                logic [c_PBITS-1:0] r_pre;

                // Count tick when the prescaler is about to wrap back to 0
                assign w_count_tick[i] = w_run_tick[i] & (&r_pre);

                // Prescaler: cleared by a load edge, advances on running ticks
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_pre <= '0;
                    end else if (w_load_rise[i]) begin
                        r_pre <= '0;
                    end else if (w_run_tick[i]) begin
                        r_pre <= r_pre + c_PBITS'(1);
                    end
                end
            end

            // Counter: preload on load edge or overflow, else increment on count ticks
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_load_rise[i] || w_wrap[i]) begin
                    r_cnt <= w_value;
                end else if (w_count_tick[i]) begin
                    r_cnt <= r_cnt + W'(1);
                end
            end
        end
    endgenerate

    // Next flag state: clear request first, so a coincident set wins
    always_comb begin
        w_flag_nxt = (r_flag & ~bus.clr_flag) | (w_wrap & bus.enable_irq);
    end

    // Load-edge history and arming advance only on ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_q <= '0;
            r_armed  <= '0;
        end else if (bus.clk_en) begin
            r_load_q <= bus.load;
            r_armed  <= r_armed | ~bus.load;
        end
    end

    // Status outputs: overflow pulse, sticky flags and interrupt from next-state flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= '0;
            r_flag     <= '0;
            r_irq_n    <= 1'b1;
        end else begin
            r_overflow <= w_wrap;
            r_flag     <= w_flag_nxt;
            r_irq_n    <= ~(|w_flag_nxt);
        end
    end

    assign bus.overflow = r_overflow;
    assign bus.flag     = r_flag;
    assign bus.irq_n    = r_irq_n;

endmodule
`default_nettype wire

// File: tb/tb_jt12_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt12_timer_bank
//  Description : Directed self-checking bench for jt12_timer_bank with a
//                per-cycle behavioural model (ticks-remaining per timer).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jt12_timer_bank;

    localparam int NT   = 2;
    localparam int W    = 10;
    localparam int PRE0 = 1;
    localparam int PREN = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    jt12_timer_bank_if #(.NTIMERS(NT), .W(W)) bus();

    jt12_timer_bank #(.NTIMERS(NT), .W(W), .PRE0(PRE0), .PREN(PREN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each timer tracks ticks remaining until its next overflow.
    // ------------------------------------------------------------------
    int            m_rem   [NT];
    bit            m_prev  [NT];
    bit            m_armed [NT];
    logic [NT-1:0] m_flag;
    logic [NT-1:0] m_ovf;
    logic [NT-1:0] m_ovf_n;
    logic          m_irq_n;
    int            m_v;

    function automatic int ratio(input int i);
        return (i == 0) ? PRE0 : PREN;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                m_rem[i] = 0; m_prev[i] = 1'b0; m_armed[i] = 1'b0;
            end
            m_flag = '0; m_ovf = '0; m_irq_n = 1'b1;
        end else begin
            m_ovf_n = '0;
            for (int i = 0; i < NT; i++) begin
                m_v = int'(bus.value[i*W +: W]);
                if (bus.clk_en) begin
                    if (bus.load[i] && m_armed[i]) begin
                        if (!m_prev[i]) begin
                            m_rem[i] = ((1 << W) - m_v) * ratio(i);
                        end else begin
                            m_rem[i] = m_rem[i] - 1;
                            if (m_rem[i] == 0) begin
                                m_ovf_n[i] = 1'b1;
                                m_rem[i] = ((1 << W) - m_v) * ratio(i);
                            end
                        end
                    end
                    if (!bus.load[i]) m_armed[i] = 1'b1;
                    m_prev[i] = bus.load[i];
                end
            end
            m_ovf   = m_ovf_n;
            m_flag  = (m_flag & ~bus.clr_flag) | (m_ovf_n & bus.enable_irq);
            m_irq_n = ~(|m_flag);
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        check("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
        check("cyc_flag",     32'(bus.flag),     32'(m_flag));
        check("cyc_irq_n",    32'(bus.irq_n),    32'(m_irq_n));
    end

    // Count clk edges until overflow[idx]; optional clk_en gap after edge gap_at
    task automatic wait_ovf(input int idx, input int limit, input int gap_at,
                            input int gap_len, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk); #2;
            n++;
            if (n == gap_at)           bus.clk_en = 1'b0;
            if (n == gap_at + gap_len) bus.clk_en = 1'b1;
            if (bus.overflow[idx]) return;
        end
        n = -1;
    endtask

    int n;
    int cnt;

    initial begin
        rst = 1'b1;
        bus.clk_en = 1'b0; bus.value = '0; bus.load = '0;
        bus.enable_irq = '0; bus.clr_flag = '0;
        repeat (3) @(negedge clk);
        check("reset_flag",  32'(bus.flag), 32'd0);
        check("reset_irq_n", 32'(bus.irq_n), 32'd1);
        check("reset_ovf",   32'(bus.overflow), 32'd0);
        rst = 1'b0; bus.clk_en = 1'b1;
        @(negedge clk);

        // Timer 0, value 1020: overflow on the 4th tick, then every 4
        bus.value[0 +: W] = 10'd1020; bus.enable_irq[0] = 1'b1; bus.load[0] = 1'b1;
        @(posedge clk);
        wait_ovf(0, 50, 0, 0, n);
        check("t0_first_ovf", n, 4);
        check("t0_flag_set",  32'(bus.flag[0]), 32'd1);
        check("t0_irq_low",   32'(bus.irq_n), 32'd0);
        wait_ovf(0, 50, 0, 0, n);
        check("t0_period", n, 4);
        @(negedge clk); bus.load[0] = 1'b0; bus.clr_flag[0] = 1'b1;
        @(negedge clk); bus.clr_flag[0] = 1'b0;
        check("t0_cleared", 32'(bus.flag[0]), 32'd0);

        // All-ones preload with irq disabled: overflow every tick, no flag
        bus.value[0 +: W] = 10'd1023; bus.enable_irq[0] = 1'b0; bus.load[0] = 1'b1;
        @(posedge clk);
        wait_ovf(0, 10, 0, 0, n);
        check("ones_first", n, 1);
        wait_ovf(0, 10, 0, 0, n);
        check("ones_period", n, 1);
        check("ones_no_flag", 32'(bus.flag[0]), 32'd0);
        @(negedge clk); bus.enable_irq[0] = 1'b1; bus.clr_flag[0] = 1'b1;
        @(posedge clk); #2;
        check("set_wins_flag", 32'(bus.flag[0]), 32'd1);
        @(negedge clk); bus.clr_flag[0] = 1'b0; bus.enable_irq[0] = 1'b0; bus.load[0] = 1'b0;
        @(negedge clk); bus.clr_flag[0] = 1'b1;
        @(negedge clk); bus.clr_flag[0] = 1'b0;
        check("clr_irq_n", 32'(bus.irq_n), 32'd1);

        // Stop at 1021 for 10 ticks, restart reloads value0
        bus.value[0 +: W] = 10'd1020; bus.load[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); bus.load[0] = 1'b0;
        cnt = 0;
        repeat (10) begin @(posedge clk); #2; if (bus.overflow[0]) cnt++; end
        check("stop_no_ovf", cnt, 0);
        @(negedge clk); bus.load[0] = 1'b1;
        @(posedge clk);
        wait_ovf(0, 50, 0, 0, n);
        check("restart_reload", n, 4);

        // Timer 1, value 1022, ratio 16: 32 ticks; 5-clock enable gap adds 5
        @(negedge clk); bus.load[0] = 1'b0;
        bus.value[W +: W] = 10'd1022; bus.enable_irq[1] = 1'b1; bus.load[1] = 1'b1;
        @(posedge clk);
        wait_ovf(1, 100, 0, 0, n);
        check("t1_first_ovf", n, 32);
        wait_ovf(1, 100, 10, 5, n);
        check("t1_gap_delay", n, 37);
        @(negedge clk); bus.load[1] = 1'b0; bus.clr_flag = 2'b11;
        @(negedge clk); bus.clr_flag = 2'b00;

        // Simultaneous overflow of both timers
        bus.value[0 +: W] = 10'd1020; bus.value[W +: W] = 10'd1023;
        bus.enable_irq = 2'b11; bus.load = 2'b11;
        @(posedge clk);
        wait_ovf(1, 100, 0, 0, n);
        check("both_t1_ovf", n, 16);
        check("both_ovf",  32'(bus.overflow), 32'h3);
        check("both_flag", 32'(bus.flag), 32'h3);
        @(negedge clk); bus.load = 2'b00; bus.clr_flag = 2'b01;
        @(negedge clk);
        check("clr01_flag",  32'(bus.flag), 32'h2);
        check("clr01_irq_n", 32'(bus.irq_n), 32'd0);
        bus.clr_flag = 2'b10;
        @(negedge clk);
        check("clr10_irq_n", 32'(bus.irq_n), 32'd1);
        bus.clr_flag = 2'b00;

        // Reset mid-run with load held high
        bus.value[0 +: W] = 10'd1020; bus.enable_irq = 2'b01; bus.load[0] = 1'b1;
        @(posedge clk);
        wait_ovf(0, 50, 0, 0, n);
        check("pre_rst_ovf", n, 4);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("async_rst_flag",  32'(bus.flag), 32'd0);
        check("async_rst_irq_n", 32'(bus.irq_n), 32'd1);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        repeat (20) begin @(posedge clk); #2; if (bus.overflow[0]) cnt++; end
        check("post_rst_idle", cnt, 0);
        @(negedge clk); bus.load[0] = 1'b0;
        @(negedge clk); bus.load[0] = 1'b1;
        @(posedge clk);
        wait_ovf(0, 50, 0, 0, n);
        check("post_rst_toggle", n, 4);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
